// File: rtl/mult_operand_sequencer.sv
// rtl/mult_operand_sequencer.sv - operand sequencer feeding a bit-serial signed 16x16 multiplier
// Optional build macro: MULT_SEQ_SELF_CHECK_EN (adds a reference product compare driving check_err).
module mult_operand_sequencer #(
    parameter int OPERAND_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OPERAND_WIDTH-1:0]     in_a,
    input  logic [OPERAND_WIDTH-1:0]     in_b,
    output logic                         mul_start,
    output logic [OPERAND_WIDTH-1:0]     mul_input1,
    output logic                         mul_input2_bit,
    input  logic [2*OPERAND_WIDTH-1:0]   mul_product,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [2*OPERAND_WIDTH-1:0]   out_product,
    output logic                         busy,
    output logic                         check_err
);

    // The serial counter, bit schedule and capture timing are built around 16-bit operands.
    if (OPERAND_WIDTH != 16) begin : g_bad_width
        $error("mult_operand_sequencer: OPERAND_WIDTH must be 16");
    end

    localparam logic [3:0] LAST_BIT = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_SHIFT   = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                       r_state;
    logic [3:0]                   r_cnt;
    logic [OPERAND_WIDTH-1:0]     r_a;
    logic [OPERAND_WIDTH-1:0]     r_b;
    logic [2*OPERAND_WIDTH-1:0]   r_out_product;
    logic                         r_in_ready;
    logic                         r_mul_start;
    logic                         r_mul_bit;
    logic                         r_out_valid;
    logic                         r_busy;

    // Sequencer FSM; every handshake/control output is a register updated alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_a           <= '0;
            r_b           <= '0;
            r_out_product <= '0;
            r_in_ready    <= 1'b1;
            r_mul_start   <= 1'b0;
            r_mul_bit     <= 1'b0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a         <= in_a;
                        r_b         <= in_b;
                        r_in_ready  <= 1'b0;
                        r_mul_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_START;
                    end
                end
                S_START: begin
                    // Present multiplier bit 0 in the first SHIFT cycle.
                    r_mul_start <= 1'b0;
                    r_cnt       <= 4'd0;
                    r_mul_bit   <= r_b[0];
                    r_state     <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_cnt == LAST_BIT) begin
                        r_mul_bit <= 1'b0;
                        r_cnt     <= 4'd0;
                        r_state   <= S_CAPTURE;
                    end else begin
                        r_mul_bit <= r_b[r_cnt + 4'd1];
                        r_cnt     <= r_cnt + 4'd1;
                    end
                end
                S_CAPTURE: begin
                    // The multiplier's final sum is on mul_product during this cycle.
                    r_out_product <= mul_product;
                    r_out_valid   <= 1'b1;
                    r_state       <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cnt       <= 4'd0;
                    r_in_ready  <= 1'b1;
                    r_mul_start <= 1'b0;
                    r_mul_bit   <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready       = r_in_ready;
    assign mul_start      = r_mul_start;
    assign mul_input1     = r_a;
    assign mul_input2_bit = r_mul_bit;
    assign out_valid      = r_out_valid;
    assign out_product    = r_out_product;
    assign busy           = r_busy;

`ifdef MULT_SEQ_SELF_CHECK_EN
    logic signed [2*OPERAND_WIDTH-1:0] w_ref_a;
    logic signed [2*OPERAND_WIDTH-1:0] w_ref_b;
    logic signed [2*OPERAND_WIDTH-1:0] w_ref_product;
    logic                              r_check_err;

    assign w_ref_a       = {{OPERAND_WIDTH{r_a[OPERAND_WIDTH-1]}}, r_a};
    assign w_ref_b       = {{OPERAND_WIDTH{r_b[OPERAND_WIDTH-1]}}, r_b};
    assign w_ref_product = w_ref_a * w_ref_b;

    // Compare the external multiplier against a reference product at capture; hold until the next capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_check_err <= 1'b0;
        end else if (r_state == S_CAPTURE) begin
            r_check_err <= (w_ref_product != mul_product);
        end
    end

    assign check_err = r_check_err;
`else
    assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// tb/tb_mult_operand_sequencer.sv - scoreboard bench for mult_operand_sequencer with a bit-serial multiplier model
module tb_mult_operand_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        mul_start;
    logic [15:0] mul_input1;
    logic        mul_input2_bit;
    logic [31:0] mul_product;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_product;
    logic        busy;
    logic        check_err;

    mult_operand_sequencer #(.OPERAND_WIDTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .mul_start      (mul_start),
        .mul_input1     (mul_input1),
        .mul_input2_bit (mul_input2_bit),
        .mul_product    (mul_product),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_product    (out_product),
        .busy           (busy),
        .check_err      (check_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp_v, cyc);
        end
    endtask

    // Bit-serial signed multiplier model: LSB first, MSB weight negative, product valid at start+17.
    logic [31:0] m_acc;
    logic [15:0] m_a;
    logic [3:0]  m_cnt;
    logic        m_active;
    logic [31:0] m_ext;
    bit          force_prod = 1'b0;

    assign m_ext       = {{16{m_a[15]}}, m_a};
    assign mul_product = force_prod ? 32'h12345678 : m_acc;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_acc    <= '0;
            m_a      <= '0;
            m_cnt    <= '0;
            m_active <= 1'b0;
        end else if (mul_start) begin
            m_acc    <= '0;
            m_a      <= mul_input1;
            m_cnt    <= '0;
            m_active <= 1'b1;
        end else if (m_active) begin
            if (mul_input2_bit) begin
                if (m_cnt == 4'd15) m_acc <= m_acc - (m_ext << m_cnt);
                else                m_acc <= m_acc + (m_ext << m_cnt);
            end
            m_cnt <= m_cnt + 4'd1;
            if (m_cnt == 4'd15) m_active <= 1'b0;
        end
    end

    function automatic logic [31:0] mul_ref(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] x;
        logic signed [31:0] y;
        x = {{16{a[15]}}, a};
        y = {{16{b[15]}}, b};
        return x * y;
    endfunction

    // Scoreboard state
    logic [31:0] exp_prod_q[$];
    logic        exp_err_q[$];
    int          t_acc = 0;
    logic [15:0] cur_a = '0;
    logic [15:0] cur_b = '0;
    bit          in_flight = 1'b0;
    int          mon_d;
    logic        prev_ov = 1'b0;
    logic        prev_or = 1'b0;
    logic [31:0] prev_prod = '0;
    logic [31:0] exp_p;
    logic        exp_e;

`ifdef MULT_SEQ_SELF_CHECK_EN
    localparam logic FORCED_ERR = 1'b1;
`else
    localparam logic FORCED_ERR = 1'b0;
`endif

    // Monitor: timing of every output against the accept cycle, result pop/compare on handshake.
    always @(negedge clk) begin
        if (reset) begin
            mon_d = cyc - t_acc;
            check("mul_start", 32'(mul_start), 32'(in_flight && mon_d == 1));
            if (in_flight && mon_d >= 2 && mon_d <= 17)
                check("b_bit", 32'(mul_input2_bit), 32'(cur_b[mon_d-2]));
            else
                check("b_bit_idle", 32'(mul_input2_bit), 32'd0);
            if (in_flight && mon_d >= 1 && mon_d <= 18)
                check("mul_input1", 32'(mul_input1), 32'(cur_a));
            check("busy", 32'(busy), 32'(in_flight && mon_d >= 1));
            check("in_ready", 32'(in_ready), 32'(!(in_flight && mon_d >= 1)));
            check("out_valid", 32'(out_valid), 32'(in_flight && mon_d >= 19));
            if (out_valid && !prev_ov && in_flight)
                check("valid_lat", 32'(mon_d), 32'd19);
            if (out_valid && prev_ov && !prev_or)
                check("hold_prod", out_product, prev_prod);
            if (out_valid && out_ready) begin
                if (exp_prod_q.size() == 0) begin
                    check("unexpected_out", 32'd1, 32'd0);
                end else begin
                    exp_p = exp_prod_q.pop_front();
                    exp_e = exp_err_q.pop_front();
                    check("product", out_product, exp_p);
                    check("check_err", 32'(check_err), 32'(exp_e));
                end
                in_flight = 1'b0;
            end
            prev_ov   = out_valid;
            prev_or   = out_ready;
            prev_prod = out_product;
        end else begin
            prev_ov = 1'b0;
            prev_or = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp_v, input logic err);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin
                exp_prod_q.push_back(exp_v);
                exp_err_q.push_back(err);
                t_acc     = cyc;
                cur_a     = a;
                cur_b     = b;
                in_flight = 1'b1;
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        check("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            if (exp_prod_q.size() == 0 && !in_flight) return;
            tick();
        end
        check("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mul_start", 32'(mul_start), 32'd0);
        check("rst_mul_input1", 32'(mul_input1), 32'd0);
        check("rst_mul_bit", 32'(mul_input2_bit), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_product", out_product, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_check_err", 32'(check_err), 32'd0);
    endtask

    logic [15:0] tab_a [4] = '{16'hFFFF, 16'hFFF9, 16'h8000, 16'h7FFF};
    logic [15:0] tab_b [4] = '{16'hFFFF, 16'h0003, 16'h8000, 16'h8000};
    logic [31:0] tab_p [4] = '{32'h00000001, 32'hFFFFFFEB, 32'h40000000, 32'hC0008000};
    logic [15:0] ra;
    logic [15:0] rb;
    int          c_r;
    bit          seen;

    initial begin
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        reset = 1'b1;
        tick();

        send(16'd3, 16'd5, 32'h0000000F, 1'b0);
        wait_done();

        for (int i = 0; i < 4; i++) begin
            send(tab_a[i], tab_b[i], tab_p[i], 1'b0);
            wait_done();
        end

        for (int i = 0; i < 4; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            send(ra, rb, mul_ref(ra, rb), 1'b0);
            wait_done();
        end

        // Backpressure with a second pair held on the input during the whole transaction.
        out_ready = 1'b0;
        send(16'h1234, 16'hFEDC, mul_ref(16'h1234, 16'hFEDC), 1'b0);
        in_a     = 16'h0101;
        in_b     = 16'h0202;
        in_valid = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else tick();
        end
        check("bp_out_valid_seen", 32'(seen), 32'd1);
        repeat (10) tick();
        out_ready = 1'b1;
        c_r = cyc;
        send(16'h0101, 16'h0202, mul_ref(16'h0101, 16'h0202), 1'b0);
        check("bp_accept_cycle", 32'(t_acc), 32'(c_r + 1));
        wait_done();

        // Reset in the middle of SHIFT with the serial counter at 7.
        send(16'h0055, 16'h00AA, mul_ref(16'h0055, 16'h00AA), 1'b0);
        repeat (8) tick();
        reset = 1'b0;
        #1;
        check_reset_outputs();
        exp_prod_q.delete();
        exp_err_q.delete();
        in_flight = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        send(16'd2, 16'hFFFE, 32'hFFFFFFFC, 1'b0);
        wait_done();

        // Corrupted multiplier result, then a clean one.
        force_prod = 1'b1;
        send(16'd3, 16'd5, 32'h12345678, FORCED_ERR);
        wait_done();
        force_prod = 1'b0;
        send(16'd3, 16'd5, 32'h0000000F, 1'b0);
        wait_done();

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1);
    end

endmodule
